// File: rtl/dom_sqscmul_gf4_checker.sv
// Response monitor for the masked GF(2^4) square-scale-multiply datapath.
// The expected result is delayed to line up with the DUT output. The output
// shares are recombined and compared against it. Checks and mismatches are
// counted with saturating counters, and the first mismatch is captured.
module dom_sqscmul_gf4_checker #(
  parameter int SHARES      = 2,
  parameter int LATENCY     = 1,
  parameter int NUM_VECTORS = 256,
  parameter int CNT_W       = 16
) (
  input  logic                  ClkxCI,
  input  logic                  RstxBI,
  input  logic                  ClearxSI,
  input  logic                  InValidxSI,
  input  logic [3:0]            ExpQxDI,
  input  logic [4*SHARES-1:0]   _QxDI,
  output logic [3:0]            QxDO,
  output logic [CNT_W-1:0]      CheckCntxDO,
  output logic [CNT_W-1:0]      ErrCntxDO,
  output logic                  ErrorxSO,
  output logic [CNT_W-1:0]      FirstErrIdxxDO,
  output logic [3:0]            FirstErrExpxDO,
  output logic [3:0]            FirstErrGotxDO,
  output logic                  DonexSO
);

  logic             w_cmp_valid;
  logic [3:0]       w_cmp_exp;
  logic [3:0]       w_q;
  logic             w_mismatch;

  logic [CNT_W-1:0] r_check_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_error;
  logic [CNT_W-1:0] r_first_idx;
  logic [3:0]       r_first_exp;
  logic [3:0]       r_first_got;

  // Recombine the output shares; the XOR of all shares is the unmasked value.
  always_comb begin
    w_q = '0;
    for (int i = 0; i < SHARES; i++) begin
      w_q = w_q ^ _QxDI[4*i +: 4];
    end
  end

  assign QxDO       = w_q;
  assign w_mismatch = (w_q != w_cmp_exp);

  if (LATENCY == 0) begin : g_nodelay
    assign w_cmp_valid = InValidxSI;
    assign w_cmp_exp   = ExpQxDI;
  end else begin : g_delay
    logic [LATENCY-1:0] r_dl_valid;
    logic [3:0]         r_dl_exp [LATENCY];

    // Shift {valid, expected} pairs so each vector reaches the tap with its DUT result.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
        r_dl_valid <= '0;
        for (int k = 0; k < LATENCY; k++) begin
          r_dl_exp[k] <= '0;
        end
      end else begin
        r_dl_valid[0] <= InValidxSI & ~ClearxSI;
        r_dl_exp[0]   <= ExpQxDI;
        for (int k = 1; k < LATENCY; k++) begin
          r_dl_valid[k] <= r_dl_valid[k-1] & ~ClearxSI;
          r_dl_exp[k]   <= r_dl_exp[k-1];
        end
      end
    end

    assign w_cmp_valid = r_dl_valid[LATENCY-1];
    assign w_cmp_exp   = r_dl_exp[LATENCY-1];
  end

  // Count compares and mismatches; freeze the first mismatch until clear or reset.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_check_cnt <= '0;
      r_err_cnt   <= '0;
      r_error     <= 1'b0;
      r_first_idx <= '0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else if (ClearxSI) begin
      r_check_cnt <= '0;
      r_err_cnt   <= '0;
      r_error     <= 1'b0;
      r_first_idx <= '0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else if (w_cmp_valid) begin
      if (r_check_cnt != '1) begin
        r_check_cnt <= r_check_cnt + CNT_W'(1);
      end
      if (w_mismatch) begin
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
        if (!r_error) begin
          r_error     <= 1'b1;
          r_first_idx <= r_check_cnt;
          r_first_exp <= w_cmp_exp;
          r_first_got <= w_q;
        end
      end
    end
  end

  assign CheckCntxDO    = r_check_cnt;
  assign ErrCntxDO      = r_err_cnt;
  assign ErrorxSO       = r_error;
  assign FirstErrIdxxDO = r_first_idx;
  assign FirstErrExpxDO = r_first_exp;
  assign FirstErrGotxDO = r_first_got;
  // The check counter only grows or saturates, so Done holds until clear/reset.
  assign DonexSO        = (64'(r_check_cnt) >= 64'(NUM_VECTORS));

endmodule

// File: tb/tb_dom_sqscmul_gf4_checker.sv
// Bench for dom_sqscmul_gf4_checker: four instances with different parameters
// share one stimulus stream. A timestamp-queue model predicts every output of
// each instance; literal expectations pin the directed scenarios.
module tb_dom_sqscmul_gf4_checker;

  logic        ClkxCI = 1'b0;
  logic        RstxBI;
  logic        ClearxSI;
  logic        InValidxSI;
  logic [3:0]  ExpQxDI;
  logic [7:0]  q_sh;
  logic [11:0] q_sh3;

  logic [3:0]  q0, q1, q2, q3;
  logic [15:0] c0, e0, f0, c1, e1, f1;
  logic [7:0]  c2, e2, f2;
  logic [3:0]  c3, e3, f3;
  logic        er0, er1, er2, er3, dn0, dn1, dn2, dn3;
  logic [3:0]  fe0, fg0, fe1, fg1, fe2, fg2, fe3, fg3;

  always #5 ClkxCI = ~ClkxCI;

  dom_sqscmul_gf4_checker #(.SHARES(2), .LATENCY(1), .NUM_VECTORS(256), .CNT_W(16)) u0 (
    .ClkxCI(ClkxCI), .RstxBI(RstxBI), .ClearxSI(ClearxSI), .InValidxSI(InValidxSI),
    .ExpQxDI(ExpQxDI), ._QxDI(q_sh), .QxDO(q0), .CheckCntxDO(c0), .ErrCntxDO(e0),
    .ErrorxSO(er0), .FirstErrIdxxDO(f0), .FirstErrExpxDO(fe0), .FirstErrGotxDO(fg0),
    .DonexSO(dn0));
  dom_sqscmul_gf4_checker #(.SHARES(2), .LATENCY(3), .NUM_VECTORS(4), .CNT_W(16)) u1 (
    .ClkxCI(ClkxCI), .RstxBI(RstxBI), .ClearxSI(ClearxSI), .InValidxSI(InValidxSI),
    .ExpQxDI(ExpQxDI), ._QxDI(q_sh), .QxDO(q1), .CheckCntxDO(c1), .ErrCntxDO(e1),
    .ErrorxSO(er1), .FirstErrIdxxDO(f1), .FirstErrExpxDO(fe1), .FirstErrGotxDO(fg1),
    .DonexSO(dn1));
  dom_sqscmul_gf4_checker #(.SHARES(2), .LATENCY(2), .NUM_VECTORS(16), .CNT_W(8)) u2 (
    .ClkxCI(ClkxCI), .RstxBI(RstxBI), .ClearxSI(ClearxSI), .InValidxSI(InValidxSI),
    .ExpQxDI(ExpQxDI), ._QxDI(q_sh), .QxDO(q2), .CheckCntxDO(c2), .ErrCntxDO(e2),
    .ErrorxSO(er2), .FirstErrIdxxDO(f2), .FirstErrExpxDO(fe2), .FirstErrGotxDO(fg2),
    .DonexSO(dn2));
  dom_sqscmul_gf4_checker #(.SHARES(3), .LATENCY(0), .NUM_VECTORS(10), .CNT_W(4)) u3 (
    .ClkxCI(ClkxCI), .RstxBI(RstxBI), .ClearxSI(ClearxSI), .InValidxSI(InValidxSI),
    .ExpQxDI(ExpQxDI), ._QxDI(q_sh3), .QxDO(q3), .CheckCntxDO(c3), .ErrCntxDO(e3),
    .ErrorxSO(er3), .FirstErrIdxxDO(f3), .FirstErrExpxDO(fe3), .FirstErrGotxDO(fg3),
    .DonexSO(dn3));

  // ---------------- behavioural model ----------------
  int lat_c  [4] = '{1, 3, 2, 0};
  int cmax_c [4] = '{65535, 65535, 255, 15};
  int nv_c   [4] = '{256, 4, 16, 10};

  typedef struct {
    int inst;
    int due;
    int exp;
  } pend_t;
  pend_t pend[$];

  int m_chk [4];
  int m_err [4];
  int m_flag[4];
  int m_fidx[4];
  int m_fexp[4];
  int m_fgot[4];
  int edge_n = 0;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  bit         hist_v [64];
  logic [3:0] hist_r [64];
  bit         hist_c [64];
  int         resp_lat = 1;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[3] ? ((aa << 1) ^ 4'h3) : (aa << 1);
    end
    return p;
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < 4; i++) begin
      m_chk[i] = 0; m_err[i] = 0; m_flag[i] = 0;
      m_fidx[i] = 0; m_fexp[i] = 0; m_fgot[i] = 0;
    end
  endtask

  task automatic score(input int i, input int e, input int got);
    if (got != e && m_flag[i] == 0) begin
      m_flag[i] = 1; m_fidx[i] = m_chk[i]; m_fexp[i] = e; m_fgot[i] = got;
    end
    if (m_chk[i] < cmax_c[i]) m_chk[i]++;
    if (got != e && m_err[i] < cmax_c[i]) m_err[i]++;
  endtask

  // One rising edge as seen by the model: vectors are stamped with the edge they are due.
  task automatic model_edge();
    int    got;
    pend_t pe;
    got = int'(q_sh[3:0] ^ q_sh[7:4]);
    edge_n++;
    if (ClearxSI) begin
      model_reset();
      return;
    end
    if (InValidxSI) begin
      for (int i = 0; i < 4; i++) begin
        pe.inst = i; pe.due = edge_n + lat_c[i]; pe.exp = int'(ExpQxDI);
        pend.push_back(pe);
      end
    end
    for (int k = pend.size() - 1; k >= 0; k--) begin
      if (pend[k].due == edge_n) begin
        score(pend[k].inst, pend[k].exp, got);
        pend.delete(k);
      end
    end
  endtask

  task automatic tick();
    @(posedge ClkxCI);
    if (RstxBI) model_edge();
    #2;
  endtask

  // Apply one cycle of stimulus; the DUT response shares follow the vector resp_lat edges later.
  task automatic drive(input bit v, input logic [3:0] res, input logic [3:0] exp,
                       input bit bad, input bit clr);
    int e;
    int s;
    logic [3:0] qv;
    logic [3:0] m;
    e = edge_n + 1;
    hist_v[e % 64] = v; hist_r[e % 64] = res; hist_c[e % 64] = bad;
    s = e - resp_lat;
    if (s >= 1 && hist_v[s % 64]) qv = hist_r[s % 64] ^ {3'b000, hist_c[s % 64]};
    else qv = 4'($urandom);
    m     = 4'($urandom);
    q_sh  = {qv ^ m, m};
    m     = 4'($urandom);
    q_sh3 = {m, q_sh[7:4] ^ m, q_sh[3:0]};
    InValidxSI = v; ExpQxDI = exp; ClearxSI = clr;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic pin(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_inst(input int i, input int q, input int chk, input int err,
                            input int flag, input int fidx, input int fexp,
                            input int fgot, input int dn);
    int wq;
    int wdn;
    wq  = int'(q_sh[3:0] ^ q_sh[7:4]);
    wdn = (m_chk[i] >= nv_c[i]) ? 1 : 0;
    n_chk++;
    if (q != wq || chk != m_chk[i] || err != m_err[i] || flag != m_flag[i] ||
        fidx != m_fidx[i] || fexp != m_fexp[i] || fgot != m_fgot[i] || dn != wdn) begin
      n_fail++;
      $display("FAIL cycle inst%0d t=%0t: dut q=%0d chk=%0d err=%0d flag=%0d fidx=%0d fexp=%0d fgot=%0d done=%0d; model q=%0d chk=%0d err=%0d flag=%0d fidx=%0d fexp=%0d fgot=%0d done=%0d",
               i, $time, q, chk, err, flag, fidx, fexp, fgot, dn,
               wq, m_chk[i], m_err[i], m_flag[i], m_fidx[i], m_fexp[i], m_fgot[i], wdn);
    end
  endtask

  // Every falling edge: all four instances against the model.
  always @(negedge ClkxCI) begin
    if (cmp_on) begin
      check_inst(0, int'(q0), int'(c0), int'(e0), int'(er0), int'(f0), int'(fe0), int'(fg0), int'(dn0));
      check_inst(1, int'(q1), int'(c1), int'(e1), int'(er1), int'(f1), int'(fe1), int'(fg1), int'(dn1));
      check_inst(2, int'(q2), int'(c2), int'(e2), int'(er2), int'(f2), int'(fe2), int'(fg2), int'(dn2));
      check_inst(3, int'(q3), int'(c3), int'(e3), int'(er3), int'(f3), int'(fe3), int'(fg3), int'(dn3));
    end
  end

  initial begin
    bit         pat [7];
    logic [3:0] r;
    logic [3:0] ex;
    logic [3:0] first_exp;
    logic [3:0] first_got;
    bit         v;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 64; k++) begin
      hist_v[k] = 1'b0; hist_r[k] = 4'h0; hist_c[k] = 1'b0;
    end
    RstxBI = 1'b0; ClearxSI = 1'b0; InValidxSI = 1'b0; ExpQxDI = 4'h0;
    q_sh = '0; q_sh3 = '0;
    model_reset();
    idle(1);
    cmp_on = 1'b1;
    idle(2);
    pin("reset chk0", int'(c0), 0);
    pin("reset err0", int'(e0), 0);
    pin("reset done0", int'(dn0), 0);
    pin("reset flag0", int'(er0), 0);
    RstxBI = 1'b1;
    idle(1);

    // Exhaustive 16x16 sweep with correct expectations, LATENCY=1 instance aligned.
    resp_lat = 1;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        r = gf_mul(gf_mul(4'(x), 4'(x)), 4'(y));
        drive(1'b1, r, r, 1'b0, 1'b0);
      end
    end
    idle(3);
    pin("sweep chk0", int'(c0), 256);
    pin("sweep err0", int'(e0), 0);
    pin("sweep flag0", int'(er0), 0);
    pin("sweep done0", int'(dn0), 1);
    pin("model sweep chk0", m_chk[0], 256);

    // One corrupted response at vector index 37 whose expected value is 4'hA.
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 64; k++) begin
      ex = (k == 37) ? 4'hA : 4'($urandom);
      drive(1'b1, ex, ex, (k == 37), 1'b0);
    end
    idle(3);
    pin("inject err0", int'(e0), 1);
    pin("inject fidx0", int'(f0), 37);
    pin("inject fexp0", int'(fe0), 10);
    pin("inject fgot0", int'(fg0), 11);
    pin("inject flag0", int'(er0), 1);
    pin("model inject fgot0", m_fgot[0], 11);

    // Bubbles on the LATENCY=3 instance, then the same stream with expectations one cycle late.
    resp_lat = 3;
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    for (int t = 0; t < 7; t++) drive(pat[t], 4'(t + 1), 4'(t + 1), 1'b0, 1'b0);
    idle(4);
    pin("bubble chk1", int'(c1), 4);
    pin("bubble err1", int'(e1), 0);
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    for (int t = 0; t < 7; t++) drive(pat[t], 4'(t + 1), 4'(t), 1'b0, 1'b0);
    idle(4);
    pin("shifted err1>0", (e1 > 0) ? 1 : 0, 1);
    pin("shifted chk1", int'(c1), 4);

    // Clear with two vectors in flight on the LATENCY=2 instance; a valid in the clear cycle is dropped.
    resp_lat = 2;
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    drive(1'b1, 4'h3, 4'h3, 1'b0, 1'b0);
    drive(1'b1, 4'h5, 4'h5, 1'b0, 1'b0);
    drive(1'b1, 4'h9, 4'h9, 1'b0, 1'b1);
    idle(3);
    pin("clear chk2", int'(c2), 0);
    pin("clear err2", int'(e2), 0);
    drive(1'b1, 4'h6, 4'h6, 1'b0, 1'b0);
    idle(3);
    pin("after clear chk2", int'(c2), 1);
    pin("after clear err2", int'(e2), 0);

    // Saturation on the 4-bit, zero-latency, three-share instance.
    resp_lat = 0;
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    first_exp = 4'h0; first_got = 4'h0;
    for (int k = 0; k < 20; k++) begin
      r = 4'($urandom);
      if (k == 0) begin first_exp = r ^ 4'hF; first_got = r; end
      drive(1'b1, r, r ^ 4'hF, 1'b0, 1'b0);
    end
    idle(1);
    pin("sat chk3", int'(c3), 15);
    pin("sat err3", int'(e3), 15);
    pin("sat fidx3", int'(f3), 0);
    pin("sat fexp3", int'(fe3), int'(first_exp));
    pin("sat fgot3", int'(fg3), int'(first_got));
    pin("sat done3", int'(dn3), 1);

    // Reset mid-run with three vectors applied on the LATENCY=2 instance.
    resp_lat = 2;
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    drive(1'b1, 4'h1, 4'h1, 1'b0, 1'b0);
    drive(1'b1, 4'h2, 4'h2, 1'b0, 1'b0);
    drive(1'b1, 4'h4, 4'h4, 1'b0, 1'b0);
    RstxBI = 1'b0;
    model_reset();
    idle(3);
    RstxBI = 1'b1;
    idle(2);
    pin("rst chk2", int'(c2), 0);
    pin("rst chk3", int'(c3), 0);
    pin("rst flag3", int'(er3), 0);
    drive(1'b1, 4'h7, 4'h7, 1'b0, 1'b0);
    idle(1);
    pin("rst lat1 chk2", int'(c2), 0);
    idle(1);
    pin("rst lat2 chk2", int'(c2), 1);

    // Random traffic: gaps, corrupted responses, wrong expectations, occasional clears.
    for (int seg = 0; seg < 8; seg++) begin
      resp_lat = int'($urandom_range(0, 3));
      for (int k = 0; k < 50; k++) begin
        v  = ($urandom_range(0, 9) < 7);
        r  = 4'($urandom);
        ex = ($urandom_range(0, 19) == 0) ? (r ^ 4'h2) : r;
        drive(v, r, ex, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
      end
    end
    idle(4);

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
